// File: rtl/pipe_fifo_stage_if.sv
// Valid/ready handshake bundle carrying one WIDTH-bit word per transfer.
interface pipe_fifo_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  // Producer side drives valid/data, consumer side drives ready.
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_fifo_stage.sv
// Elastic FIFO stage on the valid/ready pipe: circular buffer of DEPTH words.
// up_ready/down_valid come only from registered count, so down_ready never
// reaches up_ready combinationally. Words pushed at edge N are visible after
// edge N and poppable at edge N+1 (no empty bypass).
// Optional build macro PIPE_FIFO_STATS_EN adds push/pop/stall counters.
module pipe_fifo_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  pipe_fifo_stage_if.slave           up,
  pipe_fifo_stage_if.master          down,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef PIPE_FIFO_STATS_EN
  ,
  output logic [31:0]                push_count,
  output logic [31:0]                pop_count,
  output logic [31:0]                stall_count
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Elaboration-time guard on the supported depth range.
  if (DEPTH < 2 || DEPTH > 256) begin : g_depth_check
    $error("pipe_fifo_stage: DEPTH must be in 2..256");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_up_ready;
  logic             w_down_valid;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  assign w_up_ready   = reset && (r_count < CNT_W'(DEPTH));
  assign w_down_valid = (r_count != '0);
  assign w_push       = up.valid && w_up_ready;
  assign w_pop        = w_down_valid && down.ready;

  assign up.ready   = w_up_ready;
  assign down.valid = w_down_valid;
  assign down.data  = w_down_valid ? r_mem[r_rd_ptr] : '0;
  assign level      = r_count;

  // Next pointer/count values; pointers wrap at DEPTH-1 so any DEPTH works.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    end
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers; reset discards all held words.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage array; contents survive reset and are masked by count instead.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= up.data;
    end
  end

`ifdef PIPE_FIFO_STATS_EN
  // Observation-only traffic counters, wrapping modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      push_count  <= '0;
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (w_push) begin
        push_count <= push_count + 32'(1);
      end
      if (w_pop) begin
        pop_count <= pop_count + 32'(1);
      end
      if (w_down_valid && !down.ready) begin
        stall_count <= stall_count + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_fifo_stage.sv
// Self-checking bench for pipe_fifo_stage (DEPTH=4, WIDTH=8) with a queue
// scoreboard and an occupancy model. Define PIPE_FIFO_STATS_EN to also
// check the statistics counters.
module tb_pipe_fifo_stage;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic [2:0] level;
`ifdef PIPE_FIFO_STATS_EN
  logic [31:0] push_count, pop_count, stall_count;
`endif

  pipe_fifo_stage_if #(.WIDTH(8)) up_if ();
  pipe_fifo_stage_if #(.WIDTH(8)) dn_if ();

  pipe_fifo_stage #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .up    (up_if),
    .down  (dn_if),
    .level (level)
`ifdef PIPE_FIFO_STATS_EN
    ,
    .push_count  (push_count),
    .pop_count   (pop_count),
    .stall_count (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int m_lvl = 0;
  logic [7:0] q[$];

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    @(posedge clock);
    #1;
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    @(negedge clock);
  endtask

  // Advance the reference model by the transfer the next rising edge performs.
  task automatic model_xfer(input logic v, input logic [7:0] d, input logic r,
                            output logic pushed);
    logic p_ok;
    logic q_ok;
    p_ok = v && (m_lvl < DEPTH);
    q_ok = r && (m_lvl != 0);
    if (q_ok) void'(q.pop_front());
    if (p_ok) q.push_back(d);
    m_lvl  = m_lvl + int'(p_ok) - int'(q_ok);
    pushed = p_ok;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 8'hA5;
    dn_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (up_if.ready !== 1'b0) begin bad++; $display("FAIL rst_up_ready got=%0b exp=0", up_if.ready); end
      total++;
      if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL rst_down_valid got=%0b exp=0", dn_if.valid); end
      total++;
      if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    end
    #2;
    reset       = 1'b1;
    up_if.valid = 1'b0;
    #1;
    total++;
    if (up_if.ready !== 1'b1) begin bad++; $display("FAIL rel_up_ready got=%0b exp=1", up_if.ready); end
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL rel_level got=%0d exp=0", level); end
    total++;
    if (dn_if.data !== 8'h00) begin bad++; $display("FAIL rel_down_data got=%0h exp=0", dn_if.data); end
    m_lvl = 0;
    q.delete();
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [6];
    logic v, r, pushed;
    logic [7:0] d;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h55};
    for (int i = 0; i < 12; i++) begin
      v = (i < 6);
      d = (i < 6) ? vals[i] : 8'h00;
      r = (i >= 6);
      tick(v, d, r);
      total++;
      if (level !== 3'(m_lvl)) begin bad++; $display("FAIL fill_level cyc=%0d got=%0d exp=%0d", i, level, m_lvl); end
      total++;
      if (up_if.ready !== (m_lvl < DEPTH)) begin bad++; $display("FAIL fill_up_ready cyc=%0d got=%0b exp=%0b", i, up_if.ready, m_lvl < DEPTH); end
      total++;
      if (dn_if.valid !== (m_lvl != 0)) begin bad++; $display("FAIL fill_down_valid cyc=%0d got=%0b exp=%0b", i, dn_if.valid, m_lvl != 0); end
      total++;
      if (m_lvl != 0) begin
        if (dn_if.data !== q[0]) begin bad++; $display("FAIL fill_data cyc=%0d got=%0h exp=%0h", i, dn_if.data, q[0]); end
      end else if (dn_if.data !== 8'h00) begin
        bad++; $display("FAIL fill_data_empty cyc=%0d got=%0h exp=0", i, dn_if.data);
      end
      model_xfer(v, d, r, pushed);
    end
  endtask

  task automatic test_full_simul();
    logic v, r, pushed;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      v = (i < 6);
      d = 8'h90 + 8'(i);
      r = (i >= 4);
      tick(v, d, r);
      total++;
      if (level !== 3'(m_lvl)) begin bad++; $display("FAIL full_level cyc=%0d got=%0d exp=%0d", i, level, m_lvl); end
      total++;
      if (up_if.ready !== (m_lvl < DEPTH)) begin bad++; $display("FAIL full_up_ready cyc=%0d got=%0b exp=%0b", i, up_if.ready, m_lvl < DEPTH); end
      total++;
      if (dn_if.valid !== (m_lvl != 0)) begin bad++; $display("FAIL full_down_valid cyc=%0d got=%0b exp=%0b", i, dn_if.valid, m_lvl != 0); end
      if (m_lvl != 0) begin
        total++;
        if (dn_if.data !== q[0]) begin bad++; $display("FAIL full_data cyc=%0d got=%0h exp=%0h", i, dn_if.data, q[0]); end
      end
      model_xfer(v, d, r, pushed);
    end
    total++;
    if (m_lvl != 0) begin bad++; $display("FAIL full_drained got=%0d exp=0", m_lvl); end
  endtask

  task automatic test_random();
    logic v, r, pushed;
    logic [7:0] d;
    logic prev_hold;
    logic [7:0] prev_data;
    int sent;
    int cyc;
    sent = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    while ((sent < 200 || m_lvl != 0) && cyc < 3000) begin
      v = (sent < 200) && ($urandom_range(0, 1) == 1);
      d = 8'(sent * 7 + 3);
      r = ($urandom_range(0, 1) == 1);
      tick(v, d, r);
      total++;
      if (level !== 3'(m_lvl)) begin bad++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", cyc, level, m_lvl); end
      total++;
      if (dn_if.valid !== (m_lvl != 0)) begin bad++; $display("FAIL rnd_down_valid cyc=%0d got=%0b exp=%0b", cyc, dn_if.valid, m_lvl != 0); end
      if (m_lvl != 0) begin
        total++;
        if (dn_if.data !== q[0]) begin bad++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", cyc, dn_if.data, q[0]); end
      end
      if (prev_hold) begin
        total++;
        if (dn_if.data !== prev_data) begin bad++; $display("FAIL rnd_stable cyc=%0d got=%0h exp=%0h", cyc, dn_if.data, prev_data); end
      end
      prev_hold = dn_if.valid && !r;
      prev_data = dn_if.data;
      model_xfer(v, d, r, pushed);
      if (pushed) sent++;
      cyc++;
    end
    total++;
    if (cyc >= 3000) begin bad++; $display("FAIL rnd_timeout sent=%0d lvl=%0d exp_sent=200", sent, m_lvl); end
  endtask

  task automatic test_midreset();
    logic v, r, pushed;
    logic [7:0] d;
    tick(1'b1, 8'hB1, 1'b0); model_xfer(1'b1, 8'hB1, 1'b0, pushed);
    tick(1'b1, 8'hB2, 1'b0); model_xfer(1'b1, 8'hB2, 1'b0, pushed);
    tick(1'b0, 8'h00, 1'b0); model_xfer(1'b0, 8'h00, 1'b0, pushed);
    total++;
    if (level !== 3'd2) begin bad++; $display("FAIL mid_pre_level got=%0d exp=2", level); end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (dn_if.valid !== 1'b0) begin bad++; $display("FAIL mid_down_valid got=%0b exp=0", dn_if.valid); end
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level); end
    total++;
    if (up_if.ready !== 1'b0) begin bad++; $display("FAIL mid_up_ready got=%0b exp=0", up_if.ready); end
`ifdef PIPE_FIFO_STATS_EN
    total++;
    if (push_count !== 32'd0 || pop_count !== 32'd0 || stall_count !== 32'd0) begin
      bad++; $display("FAIL mid_stats got=%0d/%0d/%0d exp=0/0/0", push_count, pop_count, stall_count);
    end
`endif
    #1;
    reset = 1'b1;
    m_lvl = 0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      v = (i < 2);
      d = (i == 0) ? 8'hC1 : 8'hC2;
      r = (i >= 2);
      tick(v, d, r);
      total++;
      if (level !== 3'(m_lvl)) begin bad++; $display("FAIL mid_post_level cyc=%0d got=%0d exp=%0d", i, level, m_lvl); end
      if (m_lvl != 0) begin
        total++;
        if (dn_if.data !== q[0]) begin bad++; $display("FAIL mid_post_data cyc=%0d got=%0h exp=%0h", i, dn_if.data, q[0]); end
      end
      model_xfer(v, d, r, pushed);
    end
  endtask

  task automatic test_streaming();
    logic v, pushed;
    logic [7:0] d;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    m_lvl = 0;
    q.delete();
    for (int i = 0; i <= 20; i++) begin
      v = (i < 20);
      d = 8'(i);
      tick(v, d, 1'b1);
      total++;
      if (level !== 3'(m_lvl)) begin bad++; $display("FAIL str_level cyc=%0d got=%0d exp=%0d", i, level, m_lvl); end
      total++;
      if (dn_if.valid !== (i != 0)) begin bad++; $display("FAIL str_down_valid cyc=%0d got=%0b exp=%0b", i, dn_if.valid, i != 0); end
      if (i != 0) begin
        total++;
        if (dn_if.data !== 8'(i - 1)) begin bad++; $display("FAIL str_data cyc=%0d got=%0h exp=%0h", i, dn_if.data, 8'(i - 1)); end
      end
      model_xfer(v, d, 1'b1, pushed);
    end
    tick(1'b0, 8'h00, 1'b0);
    total++;
    if (level !== 3'd0 || dn_if.valid !== 1'b0) begin bad++; $display("FAIL str_end got=%0d/%0b exp=0/0", level, dn_if.valid); end
`ifdef PIPE_FIFO_STATS_EN
    total++;
    if (push_count !== 32'd20) begin bad++; $display("FAIL str_push_count got=%0d exp=20", push_count); end
    total++;
    if (pop_count !== 32'd20) begin bad++; $display("FAIL str_pop_count got=%0d exp=20", pop_count); end
    total++;
    if (stall_count !== 32'd0) begin bad++; $display("FAIL str_stall_count got=%0d exp=0", stall_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_random();
    test_midreset();
    test_streaming();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
